// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: loads one IN-element vector, then walks neuron_sel over OUT
//   constant-weight neurons, capturing and emitting each result in order.
// Latency: last input beat in cycle c -> first out_valid in cycle c+2+SETTLE;
//   results are spaced SETTLE+2 cycles apart while out_ready stays high.
// Backpressure: in_ready is high only in LOAD; out_ready low holds EMIT with
//   out_data/out_idx/out_last stable for as long as needed.
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_data input stream;
//   x_vec buffered vector and neuron_sel drive the external datapath, which
//   returns neuron_z; out_valid/out_ready/out_data/out_idx/out_last result
//   stream; busy is high while evaluating or emitting.
module fc_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int OUT    = 10,
  parameter int SETTLE = 1,
  parameter int ZW     = WIDTH*2 + $clog2(IN),
  localparam int CW    = (IN  > 1) ? $clog2(IN)  : 1,
  localparam int SW    = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic [IN*WIDTH-1:0] x_vec,
  output logic [SW-1:0]       neuron_sel,
  input  logic [ZW-1:0]       neuron_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ZW-1:0]       out_data,
  output logic [SW-1:0]       out_idx,
  output logic                out_last,
  output logic                busy
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [SW-1:0]       r_sel;
  logic [3:0]          r_wait;
  logic [IN*WIDTH-1:0] r_x;
  logic [ZW-1:0]       r_out_data;
  logic [SW-1:0]       r_out_idx;
  logic                r_out_last;

  logic w_cnt_last;
  logic w_sel_last;

  assign w_cnt_last = (r_cnt == CW'(IN - 1));
  assign w_sel_last = (r_sel == SW'(OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_wait     <= '0;
      r_x        <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            // Only the addressed slot is written; older slots keep their data.
            r_x[r_cnt*WIDTH +: WIDTH] <= in_data;
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_sel   <= '0;
              r_wait  <= SETTLE_L;
              r_state <= S_EVAL;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_EVAL: begin
          // The cycle that sees zero is itself a settle cycle, so EVAL spans
          // SETTLE+1 cycles before neuron_z is sampled.
          if (r_wait == 4'd0) begin
            r_out_data <= neuron_z;
            r_out_idx  <= r_sel;
            r_out_last <= w_sel_last;
            r_state    <= S_EMIT;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (w_sel_last) begin
              r_sel   <= '0;
              r_state <= S_LOAD;
            end else begin
              r_sel   <= r_sel + 1'b1;
              r_wait  <= SETTLE_L;
              r_state <= S_EVAL;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Handshake outputs decode straight from state so reset clears them at once.
  assign in_ready   = (r_state == S_LOAD);
  assign out_valid  = (r_state == S_EMIT);
  assign busy       = (r_state != S_LOAD);
  assign x_vec      = r_x;
  assign neuron_sel = r_sel;
  assign out_data   = r_out_data;
  assign out_idx    = r_out_idx;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb_fc_seq_ctrl: drives fc_seq_ctrl (IN=4, OUT=3, SETTLE=1) and a second
//   instance (IN=4, OUT=1, SETTLE=0) against a neuron model z=sel*100+sum(x).
// Expected results come from a slot-array model of the input vector.
module tb_fc_seq_ctrl;

  localparam int IN = 4;
  localparam int OUT = 3;
  localparam int SETTLE = 1;
  localparam int ZW = 18;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic [31:0] x_vec;
  logic [1:0]  neuron_sel;
  logic [ZW-1:0] neuron_z;
  logic        out_valid, out_ready;
  logic [ZW-1:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last, busy;

  logic        in_valid1, in_ready1;
  logic [7:0]  in_data1;
  logic [31:0] x_vec1;
  logic [0:0]  neuron_sel1;
  logic [ZW-1:0] neuron_z1;
  logic        out_valid1, out_ready1;
  logic [ZW-1:0] out_data1;
  logic [0:0]  out_idx1;
  logic        out_last1, busy1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [ZW-1:0] d;
    logic [1:0]    idx;
    logic          last;
    int            cyc;
  } hs_t;
  hs_t hs_q[$];

  logic [7:0] mdl_x [IN];

  function automatic logic [ZW-1:0] vsum(input logic [31:0] xv);
    return ZW'(xv[7:0]) + ZW'(xv[15:8]) + ZW'(xv[23:16]) + ZW'(xv[31:24]);
  endfunction

  assign neuron_z  = ZW'(neuron_sel) * ZW'(100) + vsum(x_vec);
  assign neuron_z1 = ZW'(neuron_sel1) * ZW'(100) + vsum(x_vec1);

  fc_seq_ctrl #(.WIDTH(8), .IN(IN), .OUT(OUT), .SETTLE(SETTLE), .ZW(ZW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_vec(x_vec), .neuron_sel(neuron_sel), .neuron_z(neuron_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  fc_seq_ctrl #(.WIDTH(8), .IN(IN), .OUT(1), .SETTLE(0), .ZW(ZW)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .x_vec(x_vec1), .neuron_sel(neuron_sel1), .neuron_z(neuron_z1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake of the main instance.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_t h;
      h.d = out_data; h.idx = out_idx; h.last = out_last; h.cyc = cyc;
      hs_q.push_back(h);
    end
  end

  function automatic int msum();
    int s = 0;
    foreach (mdl_x[k]) s += int'(mdl_x[k]);
    return s;
  endfunction

  function automatic logic [31:0] mpack();
    logic [31:0] r;
    foreach (mdl_x[k]) r[k*8 +: 8] = mdl_x[k];
    return r;
  endfunction

  // One whole frame: stream e[] with the chosen gap pattern, steer out_ready,
  // then compare the logged result beats against the model.
  task automatic run_frame(input logic [7:0] e [IN], input int gap_mode,
                           input bit block, input int stall_idx,
                           input int stall_len, input bit rnd_stall);
    int ptr = 0, c = 0, ph = 0, stall_cnt = 0, acc_cyc = -1;
    bit stalled [4];
    bit loaded;
    foreach (stalled[k]) stalled[k] = 1'b0;
    hs_q.delete();
    while (hs_q.size() < OUT && c < 300) begin
      loaded = (ptr == IN);
      if (!loaded) begin
        case (gap_mode)
          0:       in_valid = 1'b1;
          1:       in_valid = ((ph % 2) == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        ph++;
        in_data = e[ptr];
      end else begin
        in_valid = block;
        in_data  = 8'($urandom);
      end
      if (out_valid && int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
        stalled[out_idx] = 1'b1;
        if (out_data !== ZW'(stall_idx * 100 + msum())) begin
          failures++;
          $display("FAIL stall_data: got %0d want %0d", out_data, stall_idx * 100 + msum());
        end
        checks++;
      end else if (rnd_stall && out_valid && $urandom_range(0, 2) == 0) begin
        out_ready = 1'b0;
        stalled[out_idx] = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (loaded) begin
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_block: in_ready=%0b busy=%0b want 0/1", in_ready, busy);
        end
        checks++;
        if (x_vec !== mpack()) begin
          failures++;
          $display("FAIL x_hold: got %h want %h", x_vec, mpack());
        end
        checks++;
      end else if (in_valid && in_ready) begin
        mdl_x[ptr] = e[ptr];
        ptr++;
        if (ptr == IN) acc_cyc = cyc;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    if (c >= 300) begin
      failures++;
      $display("FAIL frame_timeout: got %0d beats want %0d", hs_q.size(), OUT);
    end
    checks++;
    if (x_vec !== mpack()) begin
      failures++;
      $display("FAIL x_vec: got %h want %h", x_vec, mpack());
    end
    checks++;
    for (int i = 0; i < OUT && i < hs_q.size(); i++) begin
      if (hs_q[i].d !== ZW'(i * 100 + msum())) begin
        failures++;
        $display("FAIL out_data[%0d]: got %0d want %0d", i, hs_q[i].d, i * 100 + msum());
      end
      checks++;
      if (hs_q[i].idx !== 2'(i) || hs_q[i].last !== (i == OUT - 1)) begin
        failures++;
        $display("FAIL idx_last[%0d]: got %0d/%0b want %0d/%0b", i, hs_q[i].idx, hs_q[i].last, i, i == OUT - 1);
      end
      checks++;
      if (!stalled[i]) begin
        int ref_c;
        ref_c = (i == 0) ? acc_cyc : hs_q[i-1].cyc;
        if (hs_q[i].cyc - ref_c != SETTLE + 2) begin
          failures++;
          $display("FAIL timing[%0d]: got %0d cycles want %0d", i, hs_q[i].cyc - ref_c, SETTLE + 2);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] e [IN];
    int ptr = 0, c = 0;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: got v=%0b b=%0b r=%0b l=%0b want 0/0/1/0", out_valid, busy, in_ready, out_last);
    end
    checks++;
    if (x_vec !== 32'h0 || neuron_sel !== 2'd0 || out_data !== '0 || out_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_dat: got x=%h sel=%0d d=%0d i=%0d want zeros", x_vec, neuron_sel, out_data, out_idx);
    end
    checks++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Load a vector and park in EMIT, then reset asynchronously.
    e = '{8'd5, 8'd6, 8'd7, 8'd8};
    out_ready = 1'b0;
    while (ptr < IN && c < 40) begin
      in_valid = 1'b1; in_data = e[ptr];
      @(negedge clk);
      if (in_ready) ptr++;
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    if (!out_valid) begin
      failures++;
      $display("FAIL reach_emit: got out_valid=%0b want 1", out_valid);
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_rst_ctl: got v=%0b b=%0b r=%0b want 0/0/1", out_valid, busy, in_ready);
    end
    checks++;
    if (x_vec !== 32'h0 || neuron_sel !== 2'd0) begin
      failures++;
      $display("FAIL async_rst_dat: got x=%h sel=%0d want 0/0", x_vec, neuron_sel);
    end
    checks++;
    hs_q.delete();
    foreach (mdl_x[k]) mdl_x[k] = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    if (hs_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_beat: got %0d beats v=%0b want 0/0", hs_q.size(), out_valid);
    end
    checks++;
  endtask

  task automatic test_basic();
    logic [7:0] e [IN];
    e = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame(e, 0, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [7:0] e [IN];
    e = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame(e, 0, 1'b0, 1, 7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    if (hs_q.size() != OUT) begin
      failures++;
      $display("FAIL bp_beats: got %0d want %0d", hs_q.size(), OUT);
    end
    checks++;
  endtask

  task automatic test_gaps_blocking();
    logic [7:0] e [IN];
    for (int m = 1; m <= 2; m++) begin
      foreach (e[k]) e[k] = 8'($urandom_range(0, 255));
      run_frame(e, m, 1'b1, -1, 0, 1'b0);
    end
  endtask

  task automatic test_settle0_out1();
    logic [7:0] e [IN];
    int ptr = 0, c = 0, acc = -1, hsc = -1, s = 0;
    logic [ZW-1:0] d;
    logic l, ix;
    foreach (e[k]) begin
      e[k] = 8'($urandom_range(0, 255));
      s += int'(e[k]);
    end
    out_ready1 = 1'b1;
    while (hsc < 0 && c < 60) begin
      in_valid1 = (ptr < IN);
      in_data1  = (ptr < IN) ? e[ptr] : 8'd0;
      @(negedge clk);
      if (in_valid1 && in_ready1 && ptr < IN) begin
        ptr++;
        if (ptr == IN) acc = cyc;
      end
      if (out_valid1 && out_ready1) begin
        hsc = cyc; d = out_data1; l = out_last1; ix = out_idx1;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid1 = 1'b0;
    if (hsc - acc != 2) begin
      failures++;
      $display("FAIL s0_latency: got %0d want 2", hsc - acc);
    end
    checks++;
    if (d !== ZW'(s) || l !== 1'b1 || ix !== 1'b0) begin
      failures++;
      $display("FAIL s0_result: got %0d last=%0b idx=%0b want %0d/1/0", d, l, ix, s);
    end
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL s0_return: got r=%0b v=%0b want 1/0", in_ready1, out_valid1);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [IN];
    for (int f = 0; f < 4; f++) begin
      foreach (e[k]) e[k] = 8'($urandom_range(0, 255));
      run_frame(e, (f == 0) ? 0 : 2, 1'b1, -1, 0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = 8'd0; out_ready1 = 1'b1;
    foreach (mdl_x[k]) mdl_x[k] = 8'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps_blocking();
    test_settle0_out1();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_seq_ctrl.md
Name: fc_seq_ctrl

Overview:
- Sequencer for one fully-connected layer built from constant-weight neuron datapaths (booth multipliers, add2 tree, ReLU), each producing one OUT-indexed result.
- Receives the input vector as a valid/ready stream of one WIDTH-bit element per beat and holds it stable on x_vec.
- Steps neuron_sel through all OUT neurons, waits for the combinational datapath to settle, then captures each result and emits it on a valid/ready output stream.

Parameters:
- WIDTH, 8: element width, matching the neuron datapath.
- IN, 128: input vector length.
- OUT, 10: number of neurons sequenced per vector.
- SETTLE, 1: extra wait cycles before sampling neuron_z (range 0..15).
- ZW, WIDTH*2+$clog2(IN): neuron result width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  controller accepts an element.
- in_data  input  WIDTH  input element.
- x_vec  output  IN*WIDTH  buffered vector; element k at bits [k*WIDTH +: WIDTH].
- neuron_sel  output  $clog2(OUT)  neuron currently driven or selected.
- neuron_z  input  ZW  selected neuron result, combinational from x_vec/neuron_sel.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ZW  captured result.
- out_idx  output  $clog2(OUT)  neuron index of out_data.
- out_last  output  1  out_data belongs to neuron OUT-1.
- busy  output  1  high in EVAL or EMIT.

Behaviour:
- Reset (async assert, sync release to first edge):
  - state=LOAD, element count=0, x_vec=0, neuron_sel=0, out_data=0, out_idx=0.
  - out_valid=0, out_last=0, busy=0, in_ready=1.
  - Reset mid-operation abandons the vector and any pending result. No output beat is produced.
- LOAD:
  - in_ready=1.
  - Each beat with in_valid=1 writes in_data to x_vec slot count, then count increments.
  - On the beat with count=IN-1: count wraps to 0, state goes to EVAL, neuron_sel=0, wait counter=SETTLE.
  - Slots not yet overwritten keep their previous values.
- EVAL:
  - in_ready=0, busy=1. x_vec and neuron_sel are held constant.
  - The wait counter decrements each cycle. In the cycle it reads 0: out_data<=neuron_z, out_idx<=neuron_sel, out_last<=(neuron_sel==OUT-1), state goes to EMIT.
  - EVAL therefore lasts SETTLE+1 cycles.
- EMIT:
  - out_valid=1, busy=1, in_ready=0.
  - out_data, out_idx and out_last hold until the handshake (out_valid & out_ready).
  - On the handshake, if neuron_sel<OUT-1: neuron_sel increments, state goes to EVAL, wait counter reloads SETTLE.
  - On the handshake, if neuron_sel==OUT-1: state goes to LOAD, neuron_sel=0, out_valid drops next cycle.
- Latency and throughput:
  - Last input accepted in cycle c gives the first out_valid in cycle c+2+SETTLE.
  - With out_ready held at 1, results are spaced SETTLE+2 cycles apart.
- Ordering: results are always emitted for indices 0..OUT-1 in order. No neuron is skipped or repeated.
- Back-pressure: out_ready low stalls indefinitely in EMIT with all outputs stable.
- Input beats outside LOAD: not accepted, because in_ready=0. The upstream must hold the data.
- Widths:
  - neuron_z is passed through unmodified; no truncation or sign handling, since ReLU is already applied upstream.
  - Counters are sized $clog2(IN) and $clog2(OUT).
  - OUT=1 is legal: the single result has out_last=1.

Test Plan:
- Reset/idle: assert rst mid-EMIT with IN=4, OUT=3 -> out_valid=0, busy=0, in_ready=1, x_vec=0, neuron_sel=0 immediately, without waiting for a clock edge.
- Basic frame: IN=4, OUT=3, SETTLE=1, stream 1,2,3,4 with out_ready=1 and model z=sel*100+sum(x) -> outputs 10,110,210 with idx 0,1,2 and out_last only on 210. First out_valid is 3 cycles after the 4th beat; outputs are 3 cycles apart.
- Back-pressure: same as basic frame, but hold out_ready=0 for 7 cycles on idx 1 -> out_data=110 stable throughout, no extra or duplicate beats, idx 2 follows 3 cycles after release.
- Input gaps and blocking: in_valid toggled 1,0,1,0... during LOAD -> only valid beats are counted. Driving in_valid=1 during EVAL/EMIT gets in_ready=0, and x_vec is unchanged.
- SETTLE=0 and OUT=1: single result appears 2 cycles after the last beat with out_last=1, and in_ready=1 on the cycle after the handshake.
- Back-to-back frames: second vector streamed immediately after the last handshake -> second frame's results use only the new x_vec values, and the first frame's outputs are unaffected.
